id_regfile_sb: RTL and testbench

//  Parametrised decode-stage register file with write-through bypass, a dedicated link-write port and a per-register pending-write scoreboard.

---
 rtl/id_regfile_sb_pkg.sv | 13 +
 rtl/id_regfile_sb_scoreboard.sv | 54 +++++
 rtl/id_regfile_sb.sv | 87 ++++++++
 tb/tb_id_regfile_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_sb_pkg.sv
// rtl/id_regfile_sb_pkg.sv - shared defaults and types for the ID-stage register file
package id_pkg;

  localparam int          ID_DATA_W   = 32;
  localparam int          ID_ADDR_W   = 5;
  localparam int          ID_NRD      = 2;
  localparam int          ID_GP_IDX   = 28;
  localparam logic [31:0] ID_GP_INIT  = 32'h1fffffff;
  localparam int          ID_LINK_IDX = 31;

  typedef logic [ID_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/id_regfile_sb_scoreboard.sv
// rtl/id_regfile_sb_scoreboard.sv - per-register pending-write bits and per-port hazard flags
module regfile_scoreboard
  import id_pkg::*;
#(
  parameter int ADDR_W   = ID_ADDR_W,
  parameter int NRD      = ID_NRD,
  parameter int LINK_IDX = ID_LINK_IDX
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic                  link_en,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  kill_en,
  input  logic [ADDR_W-1:0]     kill_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_pend
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_IDX);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;

  // Set is evaluated after clear so a younger issue dominates a same-cycle retire.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int r = 1; r < NUM_REGS; r++) begin
      if ((wb_en && (wb_addr == ADDR_W'(r))) || (kill_en && (kill_addr == ADDR_W'(r))))
        w_pend_nxt[r] = 1'b0;
      if (issue_en && (issue_addr == ADDR_W'(r)))
        w_pend_nxt[r] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  // A pending source whose writer retires this cycle is covered by the bypass.
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [ADDR_W-1:0] w_a;
    assign w_a        = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_pend[i] = r_pend[w_a] & (w_a != '0)
                      & ~(wb_en & (wb_addr == w_a))
                      & ~(link_en & (w_a == LINK_A));
  end

endmodule

// File: rtl/id_regfile_sb.sv
// rtl/id_regfile_sb.sv - ID register file with write-through bypass, link port and scoreboard stall
module id_regfile_sb
  import id_pkg::*;
#(
  parameter int                DATA_W   = ID_DATA_W,
  parameter int                ADDR_W   = ID_ADDR_W,
  parameter int                NRD      = ID_NRD,
  parameter int                GP_IDX   = ID_GP_IDX,
  parameter logic [DATA_W-1:0] GP_INIT  = DATA_W'(ID_GP_INIT),
  parameter int                LINK_IDX = ID_LINK_IDX
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  link_en,
  input  logic [DATA_W-1:0]     link_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  kill_en,
  input  logic [ADDR_W-1:0]     kill_addr,
  output logic [NRD-1:0]        rd_pend,
  output logic                  stall
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_IDX);

  if (GP_IDX < 0 || GP_IDX >= NUM_REGS) begin : g_bad_gp
    $error("id_regfile_sb: GP_IDX out of range");
  end
  if (LINK_IDX < 0 || LINK_IDX >= NUM_REGS) begin : g_bad_link
    $error("id_regfile_sb: LINK_IDX out of range");
  end

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Link write is issued last so it wins a same-cycle collision on LINK_IDX.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= (i == GP_IDX) ? GP_INIT : '0;
    end else begin
      if (wb_en && (wb_addr != '0))
        r_regs[wb_addr] <= wb_data;
      if (link_en && (LINK_A != '0))
        r_regs[LINK_A] <= link_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    assign w_a = rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      w_d = r_regs[w_a];
      if (w_a == '0)                     w_d = '0;
      else if (link_en && (w_a == LINK_A)) w_d = link_data;
      else if (wb_en && (w_a == wb_addr))  w_d = wb_data;
    end
    assign rd_data[i*DATA_W +: DATA_W] = w_d;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .LINK_IDX (LINK_IDX)
  ) u_sb (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .link_en    (link_en),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .kill_en    (kill_en),
    .kill_addr  (kill_addr),
    .rd_addr    (rd_addr),
    .rd_pend    (rd_pend)
  );

  assign stall = |rd_pend;

endmodule

// File: tb/tb_id_regfile_sb.sv
// tb/tb_id_regfile_sb.sv - directed and randomized checks of id_regfile_sb against a reference model
module tb_id_regfile_sb;
  import id_pkg::*;

  localparam int NRD = 3;
  localparam logic [31:0] GPV = 32'h1fffffff;

  logic              CLOCK = 1'b0;
  logic              RESET = 1'b0;
  logic              wb_en = 1'b0;
  logic [4:0]        wb_addr = '0;
  logic [31:0]       wb_data = '0;
  logic              link_en = 1'b0;
  logic [31:0]       link_data = '0;
  logic [NRD*5-1:0]  rd_addr = '0;
  logic [NRD*32-1:0] rd_data;
  logic              issue_en = 1'b0;
  logic [4:0]        issue_addr = '0;
  logic              kill_en = 1'b0;
  logic [4:0]        kill_addr = '0;
  logic [NRD-1:0]    rd_pend;
  logic              stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  id_regfile_sb #(.NRD(NRD)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .link_en(link_en), .link_data(link_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .kill_en(kill_en), .kill_addr(kill_addr),
    .rd_pend(rd_pend), .stall(stall)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference: architectural register contents and outstanding-writer set.
  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
  end

  always @(posedge CLOCK) begin
    bit nxt [32];
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_regs[28] = GPV;
    end else begin
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (link_en) m_regs[31] = link_data;
      for (int r = 0; r < 32; r++) begin
        nxt[r] = m_pend[r];
        if ((wb_en && wb_addr == r) || (kill_en && kill_addr == r)) nxt[r] = 0;
        if (issue_en && issue_addr == r && r != 0) nxt[r] = 1;
      end
      for (int r = 0; r < 32; r++) m_pend[r] = nxt[r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wb_en = 0; link_en = 0; issue_en = 0; kill_en = 0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdat(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [4:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 8) return 5'd28;
    if (r == 9) return 5'd31;
    return 5'(r);
  endfunction

  task automatic model_check();
    logic [31:0] ed;
    bit ep;
    bit any;
    int a;
    any = 0;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*5 +: 5]);
      if (a == 0)                           ed = '0;
      else if (link_en && a == 31)          ed = link_data;
      else if (wb_en && a == int'(wb_addr)) ed = wb_data;
      else                                  ed = m_regs[a];
      ep = m_pend[a] && a != 0 && !(wb_en && int'(wb_addr) == a) && !(link_en && a == 31);
      any = any | ep;
      chk($sformatf("rnd_data%0d", p), rdat(p), ed);
      chk($sformatf("rnd_pend%0d", p), 32'(rd_pend[p]), 32'(ep));
    end
    chk("rnd_stall", 32'(stall), 32'(any));
  endtask

  initial begin
    // 1: reset values, r0 immutable
    RESET = 1; tick(); RESET = 0;
    set_rd(0, 5'd28); set_rd(1, 5'd5); set_rd(2, 5'd0); settle();
    chk("rst_gp", rdat(0), GPV);
    chk("rst_r5", rdat(1), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pend", 32'(rd_pend), 32'h0);
    wb_en = 1; wb_addr = 0; wb_data = 32'hffff; set_rd(0, 5'd0); settle();
    chk("r0_bypass", rdat(0), 32'h0);
    tick(); idle(); settle();
    chk("r0_after", rdat(0), 32'h0);

    // 2: write-through bypass
    wb_en = 1; wb_addr = 8; wb_data = 32'hdead; set_rd(0, 5'd8); settle();
    chk("wb_bypass", rdat(0), 32'hdead);
    tick(); idle(); settle();
    chk("wb_array", rdat(0), 32'hdead);

    // 3: pending stall and resolution by WB
    issue_en = 1; issue_addr = 9; tick(); idle(); set_rd(0, 5'd9); settle();
    chk("pend_set", 32'(rd_pend[0]), 32'h1);
    chk("pend_stall", 32'(stall), 32'h1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h99; settle();
    chk("pend_wb_flag", 32'(rd_pend[0]), 32'h0);
    chk("pend_wb_data", rdat(0), 32'h99);
    chk("pend_wb_stall", 32'(stall), 32'h0);
    tick(); idle(); settle();
    chk("pend_cleared", 32'(rd_pend[0]), 32'h0);

    // 4: link beats WB on LINK_IDX
    wb_en = 1; wb_addr = 31; wb_data = 32'h10; link_en = 1; link_data = 32'h20;
    set_rd(0, 5'd31); settle();
    chk("link_bypass", rdat(0), 32'h20);
    tick(); idle(); settle();
    chk("link_array", rdat(0), 32'h20);

    // 5: kill clears; same-cycle issue beats wb clear
    issue_en = 1; issue_addr = 12; tick(); idle(); set_rd(1, 5'd12); settle();
    chk("kill_pre", 32'(rd_pend[1]), 32'h1);
    kill_en = 1; kill_addr = 12; tick(); idle(); settle();
    chk("kill_post", 32'(rd_pend[1]), 32'h0);
    issue_en = 1; issue_addr = 12; wb_en = 1; wb_addr = 12; wb_data = 32'h5;
    tick(); idle(); settle();
    chk("issue_wins", 32'(rd_pend[1]), 32'h1);
    chk("issue_wins_stall", 32'(stall), 32'h1);

    // 6: reset with pending bits and writes in flight
    issue_en = 1; issue_addr = 9; wb_en = 1; wb_addr = 8; wb_data = 32'h77;
    link_en = 1; link_data = 32'h55; RESET = 1;
    tick(); RESET = 0; idle();
    set_rd(0, 5'd9); set_rd(1, 5'd12); set_rd(2, 5'd28); settle();
    chk("rr_pend", 32'(rd_pend), 32'h0);
    chk("rr_stall", 32'(stall), 32'h0);
    chk("rr_r9", rdat(0), 32'h0);
    chk("rr_gp", rdat(2), GPV);
    set_rd(0, 5'd8); set_rd(1, 5'd31); settle();
    chk("rr_r8", rdat(0), 32'h0);
    chk("rr_r31", rdat(1), 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      RESET      = ($urandom_range(0, 79) == 0);
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = rand_addr();
      wb_data    = $urandom;
      link_en    = ($urandom_range(0, 5) == 0);
      link_data  = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = rand_addr();
      kill_en    = ($urandom_range(0, 5) == 0);
      kill_addr  = rand_addr();
      for (int p = 0; p < NRD; p++) set_rd(p, rand_addr());
      settle();
      if (!RESET) model_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
